// File: rtl/md_ctrl.sv
// Multiply/divide sequencing controller: fixed-latency busy counter, HI/LO ownership
// and the D-stage stall request for HI/LO users.
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        e_en,
   input  logic [2:0]  e_md_op,
   input  logic [31:0] e_a,
   input  logic [31:0] e_b,
   input  logic        d_md_use,
   output logic        busy,
   output logic        d_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [3:0] MC = 4'(MULT_CYCLES);
   localparam logic [3:0] DC = 4'(DIV_CYCLES);

   logic [0:0]  state;
   logic [3:0]  cnt;
   logic [31:0] res_hi, res_lo;

   logic        start, is_mul, is_signed, div0, neg_q;
   logic [63:0] ext_a, ext_b, prod;
   logic [31:0] mag_a, mag_b, dvsr, q, r, quo, rem;
   logic [31:0] nxt_hi, nxt_lo;

   always_comb begin
      start     = e_en && (e_md_op >= 3'd1) && (e_md_op <= 3'd4);
      is_mul    = (e_md_op == 3'd1) || (e_md_op == 3'd2);
      is_signed = (e_md_op == 3'd1) || (e_md_op == 3'd3);

      // Truncating a 64x64 product of sign-extended operands yields the signed 64-bit product.
      ext_a = is_signed ? {{32{e_a[31]}}, e_a} : {32'b0, e_a};
      ext_b = is_signed ? {{32{e_b[31]}}, e_b} : {32'b0, e_b};
      prod  = ext_a * ext_b;

      // Signed divide via magnitudes; keeps 0x80000000 / -1 well defined.
      mag_a = (is_signed && e_a[31]) ? -e_a : e_a;
      mag_b = (is_signed && e_b[31]) ? -e_b : e_b;
      div0  = (e_b == '0);
      dvsr  = div0 ? 32'd1 : mag_b;
      q     = mag_a / dvsr;
      r     = mag_a % dvsr;
      neg_q = is_signed && (e_a[31] ^ e_b[31]);
      quo   = neg_q ? -q : q;
      rem   = (is_signed && e_a[31]) ? -r : r;

      if (is_mul) begin
         nxt_hi = prod[63:32];
         nxt_lo = prod[31:0];
      end else if (div0) begin
         nxt_hi = hi;
         nxt_lo = lo;
      end else begin
         nxt_hi = rem;
         nxt_lo = quo;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         res_hi <= '0;
         res_lo <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            res_hi <= nxt_hi;
            res_lo <= nxt_lo;
            cnt    <= is_mul ? MC : DC;
            state  <= RUN;
         end else if (e_en && (e_md_op == 3'd5)) begin
            hi <= e_a;
         end else if (e_en && (e_md_op == 3'd6)) begin
            lo <= e_a;
         end
      end else begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= IDLE;
         end
      end
   end

   assign busy    = (state == RUN);
   assign d_stall = d_md_use & (busy | start);

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: stimulus queues time-tagged expectations,
// a negedge monitor compares them and measures every busy pulse length.
module tb_md_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_en;
   logic [2:0]  e_md_op;
   logic [31:0] e_a, e_b;
   logic        d_md_use;
   logic        busy, d_stall;
   logic [31:0] hi, lo;

   md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .e_en(e_en), .e_md_op(e_md_op),
      .e_a(e_a), .e_b(e_b), .d_md_use(d_md_use),
      .busy(busy), .d_stall(d_stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          due;
      bit          is_stall;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        v;
   } exp_t;

   exp_t exp_q[$];
   int   blen_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   run_len = 0;
   exp_t e;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(exp_t x);
      int i = 0;
      while (i < exp_q.size() && exp_q[i].due <= x.due) i++;
      exp_q.insert(i, x);
   endfunction

   function automatic void push_hl(string n, int due, logic [31:0] h, logic [31:0] l, logic b);
      exp_t x;
      x.name = n; x.due = due; x.is_stall = 1'b0; x.hi = h; x.lo = l; x.v = b;
      push(x);
   endfunction

   function automatic void push_st(string n, int due, logic s);
      exp_t x;
      x.name = n; x.due = due; x.is_stall = 1'b1; x.hi = '0; x.lo = '0; x.v = s;
      push(x);
   endfunction

   // Monitor: compares due expectations and busy pulse lengths.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e = exp_q.pop_front();
         checks++;
         if (e.due < cyc) begin
            errors++;
            $display("FAIL %s: missed check due cycle %0d, now cycle %0d", e.name, e.due, cyc);
         end else if (e.is_stall) begin
            if (d_stall !== e.v) begin
               errors++;
               $display("FAIL %s @%0d: d_stall=%b, expected %b", e.name, cyc, d_stall, e.v);
            end
         end else if (hi !== e.hi || lo !== e.lo || busy !== e.v) begin
            errors++;
            $display("FAIL %s @%0d: hi=%h lo=%h busy=%b, expected hi=%h lo=%h busy=%b",
                     e.name, cyc, hi, lo, busy, e.hi, e.lo, e.v);
         end
      end
      if (busy === 1'b1) begin
         run_len++;
      end else if (run_len > 0) begin
         checks++;
         if (blen_q.size() == 0) begin
            errors++;
            $display("FAIL busy_len @%0d: unexpected busy pulse of %0d cycles", cyc, run_len);
         end else begin
            int x;
            x = blen_q.pop_front();
            if (x != run_len) begin
               errors++;
               $display("FAIL busy_len @%0d: busy lasted %0d cycles, expected %0d", cyc, run_len, x);
            end
         end
         run_len = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(int t);
      while (cyc < t) step();
   endtask

   task automatic op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic en);
      e_en = en; e_md_op = o; e_a = a; e_b = b;
      step();
      e_en = 1'b0; e_md_op = 3'd0;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      int c;
      reset = 1'b1; e_en = 1'b0; e_md_op = 3'd0; e_a = '0; e_b = '0; d_md_use = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      push_hl("reset_state", cyc, 32'h0, 32'h0, 1'b0);

      // multu 0xFFFFFFFF * 2
      c = cyc;
      blen_q.push_back(5);
      push_hl("multu_busy", c + 5, 32'h0, 32'h0, 1'b1);
      push_hl("multu", c + 6, 32'h00000001, 32'hFFFFFFFE, 1'b0);
      op(3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1);
      wait_until(c + 6);

      // div -7 / 2
      c = cyc;
      blen_q.push_back(10);
      push_hl("div_busy", c + 10, 32'h00000001, 32'hFFFFFFFE, 1'b1);
      push_hl("div_neg", c + 11, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      op(3'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1);
      wait_until(c + 11);

      // divu 0xFFFFFFF9 / 2
      c = cyc;
      blen_q.push_back(10);
      push_hl("divu_busy", c + 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
      push_hl("divu", c + 11, 32'h00000001, 32'h7FFFFFFC, 1'b0);
      op(3'd4, 32'hFFFFFFF9, 32'h00000002, 1'b1);
      wait_until(c + 11);

      // stall window around mult 3*4, with mthi injected mid-run
      c = cyc;
      d_md_use = 1'b1;
      for (int k = 0; k <= 5; k++) push_st("stall_busy", c + k, 1'b1);
      push_st("stall_free", c + 6, 1'b0);
      push_st("stall_idle", c + 7, 1'b0);
      blen_q.push_back(5);
      push_hl("mthi_in_run", c + 3, 32'h00000001, 32'h7FFFFFFC, 1'b1);
      push_hl("mult_small", c + 6, 32'h0, 32'h0000000C, 1'b0);
      op(3'd1, 32'd3, 32'd4, 1'b1);
      step();
      op(3'd5, 32'hDEADBEEF, 32'h0, 1'b1);
      wait_until(c + 7);
      d_md_use = 1'b0;
      wait_until(c + 8);

      // mthi/mtlo, then the same ops with e_en low
      c = cyc;
      push_hl("mthi", c + 1, 32'h12345678, 32'h0000000C, 1'b0);
      push_hl("mtlo", c + 2, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      push_hl("en_low_a", c + 4, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      push_hl("en_low_b", c + 6, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      op(3'd5, 32'h12345678, 32'h0, 1'b1);
      op(3'd6, 32'h9ABCDEF0, 32'h0, 1'b1);
      op(3'd5, 32'h11111111, 32'h0, 1'b0);
      op(3'd6, 32'h22222222, 32'h0, 1'b0);
      op(3'd1, 32'd5, 32'd5, 1'b0);
      wait_until(c + 7);

      // divu by zero leaves hi/lo untouched
      c = cyc;
      blen_q.push_back(10);
      push_hl("preset_hilo", c + 2, 32'hAAAA0000, 32'h0000BBBB, 1'b0);
      push_hl("div0_busy", c + 12, 32'hAAAA0000, 32'h0000BBBB, 1'b1);
      push_hl("div0_done", c + 13, 32'hAAAA0000, 32'h0000BBBB, 1'b0);
      op(3'd5, 32'hAAAA0000, 32'h0, 1'b1);
      op(3'd6, 32'h0000BBBB, 32'h0, 1'b1);
      op(3'd4, 32'h12345678, 32'h0, 1'b1);
      wait_until(c + 13);

      // div 0x80000000 / -1
      c = cyc;
      blen_q.push_back(10);
      push_hl("div_ovf_busy", c + 10, 32'hAAAA0000, 32'h0000BBBB, 1'b1);
      push_hl("div_ovf", c + 11, 32'h0, 32'h80000000, 1'b0);
      op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_until(c + 11);

      // mult -1 * -1
      c = cyc;
      blen_q.push_back(5);
      push_hl("mult_m1_busy", c + 5, 32'h0, 32'h80000000, 1'b1);
      push_hl("mult_m1", c + 6, 32'h0, 32'h00000001, 1'b0);
      op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      wait_until(c + 6);

      // reset during busy cycle 4 of a div; no late write afterwards
      c = cyc;
      blen_q.push_back(4);
      push_hl("pre_reset", c + 5, 32'h55555555, 32'h00000001, 1'b1);
      push_hl("mid_reset", c + 6, 32'h0, 32'h0, 1'b0);
      for (int k = 7; k <= 17; k++) push_hl("post_reset", c + k, 32'h0, 32'h0, 1'b0);
      op(3'd5, 32'h55555555, 32'h0, 1'b1);
      op(3'd3, 32'd100, 32'd7, 1'b1);
      wait_until(c + 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_until(c + 19);

      if (exp_q.size() != 0 || blen_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d checks and %0d busy pulses left pending, expected 0",
                  exp_q.size(), blen_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
